// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: walks a 4-input function unit through minterms 0..15.
// It holds each minterm on {a,b,c,d} for SETTLE cycles and then samples func_in
// into a 16-bit truth table. At the end it compares that table against the
// expected mask that was latched when start was accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | results held; a start here launches a sweep
// RUN   | minterm idx driven out, hold counts settle cycles, then sample
// DONE  | single-cycle done pulse; results are final; start ignored
module kmap_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        func_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        match,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail
);

    // Last value of the hold counter for a minterm. Sampling happens on that edge.
    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] truth_q, truth_d;
    logic [4:0]  mm_q, mm_d;
    logic [3:0]  ff_q, ff_d;
    logic        match_q, match_d;
    logic        sample_fail;
    logic [4:0]  mm_inc;

    // Next-state and result-update logic for the sweep.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        exp_d       = exp_q;
        truth_d     = truth_q;
        mm_d        = mm_q;
        ff_d        = ff_q;
        match_d     = match_q;
        sample_fail = 1'b0;
        mm_inc      = mm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    hold_d  = 4'd0;
                    exp_d   = expected;
                    truth_d = 16'd0;
                    mm_d    = 5'd0;
                    ff_d    = 4'd0;
                    match_d = 1'b0;
                end
            end
            RUN: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    truth_d[idx_q] = func_in;
                    sample_fail    = (func_in != exp_q[idx_q]);
                    mm_inc         = mm_q + {4'd0, sample_fail};
                    mm_d           = mm_inc;
                    // A zero count before this sample means this sample is the first failure.
                    if (sample_fail && (mm_q == 5'd0)) begin
                        ff_d = idx_q;
                    end
                    hold_d = 4'd0;
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        match_d = (mm_inc == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            hold_q  <= 4'd0;
            exp_q   <= 16'd0;
            truth_q <= 16'd0;
            mm_q    <= 5'd0;
            ff_q    <= 4'd0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            exp_q   <= exp_d;
            truth_q <= truth_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
            match_q <= match_d;
        end
    end

    assign {a, b, c, d}   = idx_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign truth          = truth_q;
    assign match          = match_q;
    assign mismatch_count = mm_q;
    assign first_fail     = ff_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Bench for kmap_sweep_ctrl. It uses two instances:
//   u_s1: SETTLE=1, fed by a combinational function that the bench selects.
//   u_s3: SETTLE=3, fed by 4-input parity delayed through two registers.
// Each instance has a scoreboard queue. An entry is pushed when a start is
// about to be accepted, and it is popped and checked on the done pulse.
module tb_kmap_sweep_ctrl;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] exp;
        logic [15:0] truth;
        logic [4:0]  mm;
        logic [3:0]  ff;
        logic        match;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Instance with SETTLE=1.
    logic        reset1, start1, func1;
    logic [15:0] exp1;
    logic [1:0]  sel1;
    logic        a1, b1, c1, d1, busy1, done1, match1;
    logic [15:0] truth1;
    logic [4:0]  mm1;
    logic [3:0]  ff1;

    // Instance with SETTLE=3.
    logic        reset3, start3, func3;
    logic [15:0] exp3;
    logic        a3, b3, c3, d3, busy3, done3, match3;
    logic [15:0] truth3;
    logic [4:0]  mm3;
    logic [3:0]  ff3;
    logic        p1, p2;

    kmap_sweep_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset1), .start(start1), .expected(exp1), .func_in(func1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .truth(truth1), .match(match1), .mismatch_count(mm1), .first_fail(ff1)
    );

    kmap_sweep_ctrl #(.SETTLE(3)) u_s3 (
        .clk(clk), .reset(reset3), .start(start3), .expected(exp3), .func_in(func3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .truth(truth3), .match(match3), .mismatch_count(mm3), .first_fail(ff3)
    );

    function automatic logic fv(input logic [1:0] sel, input logic [3:0] m);
        case (sel)
            2'd0:    return ^m;
            2'd1:    return (m[3] & m[2]) | (m[1] & ~m[0]);
            default: return m[3] | m[0];
        endcase
    endfunction

    function automatic vec_t ref_rec(input logic [1:0] sel, input logic [15:0] e);
        vec_t r;
        logic [15:0] diff;
        r.sel   = sel;
        r.exp   = e;
        r.truth = 16'd0;
        for (int i = 0; i < 16; i++) r.truth[i] = fv(sel, 4'(i));
        diff  = r.truth ^ e;
        r.mm  = 5'd0;
        r.ff  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                r.mm = r.mm + 5'd1;
                r.ff = 4'(i);
            end
        end
        r.match = (r.mm == 5'd0);
        return r;
    endfunction

    assign func1 = fv(sel1, {a1, b1, c1, d1});
    assign func3 = p2;

    // Function unit with a two-register output delay for the SETTLE=3 instance.
    always @(posedge clk) begin
        p1 <= ^{a3, b3, c3, d3};
        p2 <= p1;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_res(input string tag, input vec_t e, input logic [15:0] t,
                             input logic [4:0] mm, input logic [3:0] ff, input logic m,
                             input int lat, input int bcnt, input bit seq_bad, input int s);
        chk({tag, "_truth"}, 32'(t), 32'(e.truth));
        chk({tag, "_mismatch_count"}, 32'(mm), 32'(e.mm));
        chk({tag, "_first_fail"}, 32'(ff), 32'(e.ff));
        chk({tag, "_match"}, 32'(m), 32'(e.match));
        chk({tag, "_done_latency"}, 32'(lat), 32'(16 * s + 1));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(16 * s));
        chk({tag, "_minterm_sequence"}, 32'(seq_bad), 32'd0);
    endtask

    // Scoreboard and protocol monitor for u_s1.
    vec_t sbq1[$];
    vec_t nxt1;
    int   dstamp1[$];
    int   e01 = 0, bcnt1 = 0;
    bit   seq_bad1 = 0, prev_done1 = 0;
    always @(negedge clk) begin
        if (reset1) begin
            sbq1.delete();
            prev_done1 = 0;
        end else begin
            if (prev_done1) chk("s1_done_width", 32'(done1), 32'd0);
            prev_done1 = done1;
            if (busy1) begin
                if ({a1, b1, c1, d1} != 4'(bcnt1)) seq_bad1 = 1;
                bcnt1++;
            end
            if (done1) begin
                dstamp1.push_back(cyc);
                chk("s1_busy_during_done", 32'(busy1), 32'd0);
                chk("s1_sb_entry_at_done", 32'(sbq1.size() > 0), 32'd1);
                if (sbq1.size() > 0)
                    check_res("s1", sbq1.pop_front(), truth1, mm1, ff1, match1,
                              cyc - e01 + 1, bcnt1, seq_bad1, 1);
            end
            if (!busy1 && !done1 && start1) begin
                sbq1.push_back(nxt1);
                e01 = cyc + 1;
                bcnt1 = 0;
                seq_bad1 = 0;
            end
        end
    end

    // Scoreboard and protocol monitor for u_s3.
    vec_t sbq3[$];
    vec_t nxt3;
    int   dstamp3[$];
    int   e03 = 0, bcnt3 = 0;
    bit   seq_bad3 = 0, prev_done3 = 0;
    always @(negedge clk) begin
        if (reset3) begin
            sbq3.delete();
            prev_done3 = 0;
        end else begin
            if (prev_done3) chk("s3_done_width", 32'(done3), 32'd0);
            prev_done3 = done3;
            if (busy3) begin
                if ({a3, b3, c3, d3} != 4'(bcnt3 / 3)) seq_bad3 = 1;
                bcnt3++;
            end
            if (done3) begin
                dstamp3.push_back(cyc);
                chk("s3_busy_during_done", 32'(busy3), 32'd0);
                chk("s3_sb_entry_at_done", 32'(sbq3.size() > 0), 32'd1);
                if (sbq3.size() > 0)
                    check_res("s3", sbq3.pop_front(), truth3, mm3, ff3, match3,
                              cyc - e03 + 1, bcnt3, seq_bad3, 3);
            end
            if (!busy3 && !done3 && start3) begin
                sbq3.push_back(nxt3);
                e03 = cyc + 1;
                bcnt3 = 0;
                seq_bad3 = 0;
            end
        end
    end

    task automatic sweep1(input vec_t v);
        int n0;
        bit got;
        @(posedge clk); #1;
        sel1 = v.sel; exp1 = v.exp; nxt1 = v; start1 = 1'b1;
        n0 = dstamp1.size();
        @(posedge clk); #1;
        start1 = 1'b0;
        exp1 = ~v.exp;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (dstamp1.size() > n0) got = 1;
        end
        chk("s1_sweep_finished", 32'(got), 32'd1);
    endtask

    task automatic sweep3(input vec_t v);
        int n0;
        bit got;
        @(posedge clk); #1;
        exp3 = v.exp; nxt3 = v; start3 = 1'b1;
        n0 = dstamp3.size();
        @(posedge clk); #1;
        start3 = 1'b0;
        exp3 = ~v.exp;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            if (dstamp3.size() > n0) got = 1;
        end
        chk("s3_sweep_finished", 32'(got), 32'd1);
    endtask

    vec_t vecs[7];
    vec_t v_par;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit got;
        reset1 = 1'b1; start1 = 1'b0; exp1 = 16'd0; sel1 = 2'd0;
        reset3 = 1'b1; start3 = 1'b0; exp3 = 16'd0;
        nxt1 = ref_rec(2'd0, 16'h6996);
        nxt3 = nxt1;

        // Vector table. The rows for the parity unit use hand-derived constants.
        vecs[0] = '{2'd0, 16'h6996,           16'h6996, 5'd0,  4'd0,  1'b1};
        vecs[1] = '{2'd0, 16'h6996 ^ 16'h8010, 16'h6996, 5'd2,  4'd4,  1'b0};
        vecs[2] = '{2'd0, 16'h9669,           16'h6996, 5'd16, 4'd0,  1'b0};
        vecs[3] = '{2'd0, 16'h6996 ^ 16'h8000, 16'h6996, 5'd1,  4'd15, 1'b0};
        vecs[4] = ref_rec(2'd1, 16'($urandom));
        vecs[5] = ref_rec(2'd2, 16'($urandom));
        vecs[6] = ref_rec(2'd1, 16'h00f0);
        v_par   = vecs[0];

        repeat (3) @(posedge clk);
        #1;
        chk("s1_reset_values", {a1, b1, c1, d1, busy1, done1, truth1, match1, mm1, ff1}, 32'd0);
        chk("s3_reset_values", {a3, b3, c3, d3, busy3, done3, truth3, match3, mm3, ff3}, 32'd0);
        reset1 = 1'b0;
        reset3 = 1'b0;

        // Single sweeps driven from the vector table.
        for (int i = 0; i < 7; i++) sweep1(vecs[i]);

        // SETTLE=3 instance with a delayed unit: parity match, then one failure at minterm 0.
        sweep3(v_par);
        sweep3('{2'd0, 16'h6996 ^ 16'h0001, 16'h6996, 5'd1, 4'd0, 1'b0});

        // Start held high. Expected changes while busy must have no effect.
        @(posedge clk); #1;
        nxt1 = v_par; sel1 = 2'd0; exp1 = 16'h6996; start1 = 1'b1;
        n0 = dstamp1.size();
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            exp1 = busy1 ? 16'($urandom) : 16'h6996;
            if (dstamp1.size() >= n0 + 3) got = 1;
        end
        start1 = 1'b0;
        chk("s1_back_to_back_three_done", 32'(got), 32'd1);
        if (got) begin
            chk("s1_done_period_1", 32'(dstamp1[n0 + 1] - dstamp1[n0]), 32'd18);
            chk("s1_done_period_2", 32'(dstamp1[n0 + 2] - dstamp1[n0 + 1]), 32'd18);
        end

        // Reset while minterm 7 is being driven.
        @(posedge clk); #1;
        nxt1 = v_par; sel1 = 2'd0; exp1 = 16'h6996; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (busy1 && ({a1, b1, c1, d1} == 4'd7)) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("s1_reached_minterm7", 32'(got), 32'd1);
        reset1 = 1'b1;
        @(posedge clk); #1;
        reset1 = 1'b0;
        chk("s1_midsweep_reset_values", {a1, b1, c1, d1, busy1, done1, truth1, match1, mm1, ff1}, 32'd0);
        n0 = dstamp1.size();
        repeat (40) @(posedge clk);
        #1;
        chk("s1_no_done_after_reset", 32'(dstamp1.size() - n0), 32'd0);
        sweep1(vecs[1]);
        sweep1(vecs[0]);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
